// File: rtl/shift_left32.sv
// Fixed logical left shift by SHAMT with an overflow flag for bits lost off the top.
// Combinational y/ovf plus a one-cycle registered copy under synchronous active-low reset.

module shift_left32 #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHAMT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y,
  output logic             ovf,
  output logic [WIDTH-1:0] y_r,
  output logic             ovf_r
);

  logic [WIDTH-1:0] y_r_d, y_r_q;
  logic             ovf_r_d, ovf_r_q;

  assign y = a << SHAMT;

  // Guard against a zero-width slice of a when no bits are shifted out.
  generate
    if (SHAMT == 0) begin : g_no_ovf
      assign ovf = 1'b0;
    end else begin : g_ovf
      assign ovf = |a[WIDTH-1 -: SHAMT];
    end
  endgenerate

  always_comb begin
    y_r_d   = y;
    ovf_r_d = ovf;
    if (!rst) begin
      y_r_d   = '0;
      ovf_r_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    y_r_q   <= y_r_d;
    ovf_r_q <= ovf_r_d;
  end

  assign y_r   = y_r_q;
  assign ovf_r = ovf_r_q;

endmodule

// File: tb/tb_shift_left32.sv
// Self-checking bench for shift_left32: directed vectors plus randomized traffic
// compared against an arithmetic reference (multiply by 4, overflow if a >= 2^30).

module tb_shift_left32;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] y;
  logic        ovf;
  logic [31:0] y_r;
  logic        ovf_r;

  int tests_run;
  int tests_failed;

  shift_left32 #(
    .WIDTH(32),
    .SHAMT(2)
  ) u_dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .y    (y),
    .ovf  (ovf),
    .y_r  (y_r),
    .ovf_r(ovf_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_y(input logic [31:0] v);
    logic [63:0] p;
    p = {32'd0, v} * 64'd4;
    return p[31:0];
  endfunction

  function automatic logic ref_ovf(input logic [31:0] v);
    return ({32'd0, v} >= 64'h4000_0000);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] dir_a   [6];
  logic [31:0] dir_y   [6];
  logic        dir_ovf [6];

  initial begin
    logic [31:0] v;
    logic        r;
    tests_run    = 0;
    tests_failed = 0;
    dir_a[0] = 32'h0000_0001; dir_y[0] = 32'h0000_0004; dir_ovf[0] = 1'b0;
    dir_a[1] = 32'hFFFF_FFFF; dir_y[1] = 32'hFFFF_FFFC; dir_ovf[1] = 1'b1;
    dir_a[2] = 32'h4000_0000; dir_y[2] = 32'h0000_0000; dir_ovf[2] = 1'b1;
    dir_a[3] = 32'h3FFF_FFFF; dir_y[3] = 32'hFFFF_FFFC; dir_ovf[3] = 1'b0;
    dir_a[4] = 32'h0000_0000; dir_y[4] = 32'h0000_0000; dir_ovf[4] = 1'b0;
    dir_a[5] = 32'h1234_5678; dir_y[5] = 32'h48D1_59E0; dir_ovf[5] = 1'b0;

    rst = 1'b0;
    a   = 32'hFFFF_FFFF;
    tick();
    check("reset_y_r", y_r, 32'h0);
    check("reset_ovf_r", {31'd0, ovf_r}, 32'h0);
    check("reset_y_tracks_a", y, 32'hFFFF_FFFC);
    check("reset_ovf_tracks_a", {31'd0, ovf}, 32'h1);
    rst = 1'b1;

    // Directed vectors: combinational result, then the registered copy.
    for (int i = 0; i < 6; i++) begin
      a = dir_a[i];
      #1;
      check("dir_y", y, dir_y[i]);
      check("dir_ovf", {31'd0, ovf}, {31'd0, dir_ovf[i]});
      tick();
      check("dir_y_r", y_r, dir_y[i]);
      check("dir_ovf_r", {31'd0, ovf_r}, {31'd0, dir_ovf[i]});
    end

    // Reset wins over the load at the same edge, then release captures current a.
    a   = 32'h0000_0003;
    rst = 1'b0;
    tick();
    check("rst_y_r", y_r, 32'h0);
    check("rst_ovf_r", {31'd0, ovf_r}, 32'h0);
    check("rst_y", y, 32'h0000_000C);
    rst = 1'b1;
    tick();
    check("release_y_r", y_r, 32'h0000_000C);

    // Combinational path follows a between edges; the register does not.
    a = 32'h0000_0001;
    #1;
    check("between_y_1", y, 32'h0000_0004);
    check("between_y_r_hold_1", y_r, 32'h0000_000C);
    a = 32'h0000_0002;
    #1;
    check("between_y_2", y, 32'h0000_0008);
    check("between_y_r_hold_2", y_r, 32'h0000_000C);
    tick();
    check("between_y_r_load", y_r, 32'h0000_0008);

    // Randomized traffic with occasional reset cycles.
    for (int i = 0; i < 300; i++) begin
      v = $urandom();
      if ((i % 4) == 1) v = v >> ($urandom_range(0, 31));
      r = ($urandom_range(0, 9) != 0);
      a   = v;
      rst = r;
      #1;
      check("rnd_y", y, ref_y(v));
      check("rnd_ovf", {31'd0, ovf}, {31'd0, ref_ovf(v)});
      tick();
      check("rnd_y_r", y_r, r ? ref_y(v) : 32'h0);
      check("rnd_ovf_r", {31'd0, ovf_r}, {31'd0, r ? ref_ovf(v) : 1'b0});
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
